// File: rtl/risc_v_mem_bus_arbiter.sv
// Two-port round-robin arbiter and 3-cycle transfer sequencer for the
// memory controller bus (port 0 = core LSU, port 1 = UART loader/debug).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mX_req/we/addr/wdata request side of port X (held until mX_gnt)
//   mX_gnt              combinational grant in IDLE
//   mX_ack/err/rdata    one-cycle completion in RESP
//   mem_bus_*           strobes/addresses/data toward memory controller
module risc_v_mem_bus_arbiter #(
  parameter int DATA_W          = 32,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [DATA_W-1:0] mem_bus_rd_addr,
  output logic [DATA_W-1:0] mem_bus_wr_addr,
  output logic              mem_bus_read,
  output logic              mem_bus_write,
  output logic [DATA_W-1:0] mem_bus_wr_data,
  input  logic [DATA_W-1:0] mem_bus_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic              r_last;
  logic              r_port;
  logic              r_we;
  logic              r_err;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_any;
  logic              w_win;
  logic              w_we;
  logic              w_mis;
  logic [DATA_W-1:0] w_addr;
  logic [DATA_W-1:0] w_addr_l;
  logic [DATA_W-1:0] w_wdata;
  logic              w_idle;

  assign w_idle = (r_state == S_IDLE);

  // Tie goes to the port that did not win last; lone requester wins.
  always_comb begin
    w_any   = m0_req | m1_req;
    w_win   = (m0_req & m1_req) ? ~r_last : m1_req;
    w_we    = w_win ? m1_we    : m0_we;
    w_addr  = w_win ? m1_addr  : m0_addr;
    w_wdata = w_win ? m1_wdata : m0_wdata;
    w_mis   = |w_addr[1:0];
    if (ERR_ON_MISALIGN) begin
      w_addr_l = w_addr;
    end else begin
      w_addr_l = {w_addr[DATA_W-1:2], 2'b00};
    end
  end

  // Grants are masked while reset is held so they read 0 in reset.
  assign m0_gnt = rst_n & w_idle & w_any & ~w_win;
  assign m1_gnt = rst_n & w_idle & w_any & w_win;

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_state_nx = S_ISSUE;
      S_ISSUE: w_state_nx = S_RESP;
      S_RESP:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Bus and response outputs decode straight from state so that an
  // asynchronous reset drops them immediately.
  always_comb begin
    mem_bus_read    = 1'b0;
    mem_bus_write   = 1'b0;
    mem_bus_rd_addr = '0;
    mem_bus_wr_addr = '0;
    mem_bus_wr_data = '0;
    m0_ack          = 1'b0;
    m0_err          = 1'b0;
    m0_rdata        = '0;
    m1_ack          = 1'b0;
    m1_err          = 1'b0;
    m1_rdata        = '0;
    if (r_state == S_ISSUE && !r_err) begin
      if (r_we) begin
        mem_bus_write   = 1'b1;
        mem_bus_wr_addr = r_addr;
        mem_bus_wr_data = r_wdata;
      end else begin
        mem_bus_read    = 1'b1;
        mem_bus_rd_addr = r_addr;
      end
    end
    if (r_state == S_RESP) begin
      if (r_port) begin
        m1_ack   = 1'b1;
        m1_err   = r_err;
        m1_rdata = r_rdata;
      end else begin
        m0_ack   = 1'b1;
        m0_err   = r_err;
        m0_rdata = r_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_idle && w_any) begin
        r_port  <= w_win;
        r_last  <= w_win;
        r_we    <= w_we;
        r_addr  <= w_addr_l;
        r_wdata <= w_wdata;
        r_err   <= ERR_ON_MISALIGN & w_mis;
      end
      if (r_state == S_ISSUE) begin
        r_rdata <= (!r_we && !r_err) ? mem_bus_rd_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_risc_v_mem_bus_arbiter.sv
// Testbench for risc_v_mem_bus_arbiter: directed scenarios plus a
// randomized run against a cycle-timeline reference model.
module tb_risc_v_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_bus_rd_addr, mem_bus_wr_addr, mem_bus_wr_data;
  logic        mem_bus_read, mem_bus_write;
  logic [31:0] mem_bus_rd_data;

  int checks = 0;
  int errors = 0;

  risc_v_mem_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack),
    .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ack(m1_ack),
    .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_bus_rd_addr(mem_bus_rd_addr),
    .mem_bus_wr_addr(mem_bus_wr_addr),
    .mem_bus_read(mem_bus_read), .mem_bus_write(mem_bus_write),
    .mem_bus_wr_data(mem_bus_wr_data),
    .mem_bus_rd_data(mem_bus_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h1001_0004) return 32'h1234_5678;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign mem_bus_rd_data = memf(mem_bus_rd_addr);

  function automatic logic [167:0] outs();
    return {m0_gnt, m1_gnt, mem_bus_read, mem_bus_write,
            mem_bus_rd_addr, mem_bus_wr_addr, mem_bus_wr_data,
            m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    m0_req = 1; m1_req = 1;
    #2;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL reset_async got=%h want=0", outs());
    end
    @(negedge clk);
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL reset_held got=%h want=0", outs());
    end
    idle_inputs();
    step();
    rst_n = 1;
  endtask

  task automatic test_write();
    do_reset();
    m0_req = 1; m0_we = 1;
    m0_addr = 32'h1001_0000; m0_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL wr_gnt got=%b want=10", {m0_gnt, m1_gnt});
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({mem_bus_write, mem_bus_read, mem_bus_wr_addr, mem_bus_wr_data,
         m0_gnt} !== {2'b10, 32'h1001_0000, 32'hDEAD_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL wr_issue got=%b%b %h %h want=10 10010000 deadbeef",
               mem_bus_write, mem_bus_read, mem_bus_wr_addr,
               mem_bus_wr_data);
    end
    step();
    @(negedge clk);
    checks++;
    if ({m0_ack, m0_err, m0_rdata, m1_ack} !== {2'b10, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL wr_resp got=%b%b %h %b want=10 0 0",
               m0_ack, m0_err, m0_rdata, m1_ack);
    end
    step();
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack_pulse got=%b want=0", m0_ack);
    end
  endtask

  task automatic test_read();
    step();
    m1_req = 1; m1_we = 0; m1_addr = 32'h1001_0004;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL rd_gnt got=%b want=01", {m0_gnt, m1_gnt});
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({mem_bus_read, mem_bus_write, mem_bus_rd_addr} !==
        {2'b10, 32'h1001_0004}) begin
      errors++;
      $display("FAIL rd_issue got=%b%b %h want=10 10010004",
               mem_bus_read, mem_bus_write, mem_bus_rd_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if ({m1_ack, m1_err, m1_rdata, m0_ack} !==
        {2'b10, 32'h1234_5678, 1'b0}) begin
      errors++;
      $display("FAIL rd_resp got=%b%b %h m0ack=%b want=10 12345678 0",
               m1_ack, m1_err, m1_rdata, m0_ack);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h1001_0010; m0_wdata = 32'h1;
    m1_req = 1; m1_we = 0; m1_addr = 32'h1001_0020;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== {c % 6 == 0, c % 6 == 3}) begin
        errors++;
        $display("FAIL rr_cycle%0d got=%b want=%b%b", c,
                 {m0_gnt, m1_gnt}, c % 6 == 0, c % 6 == 3);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_misalign();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h1001_0002;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL mis_gnt got=%b want=1", m0_gnt);
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({mem_bus_read, mem_bus_write} !== 2'b00) begin
      errors++;
      $display("FAIL mis_strobe got=%b%b want=00",
               mem_bus_read, mem_bus_write);
    end
    step();
    @(negedge clk);
    checks++;
    if ({m0_ack, m0_err, m0_rdata} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL mis_resp got=%b%b %h want=11 0",
               m0_ack, m0_err, m0_rdata);
    end
  endtask

  task automatic test_reset_mid();
    bit acked;
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h1001_0040; m0_wdata = 32'h55;
    step();
    idle_inputs();
    #2;
    checks++;
    if (mem_bus_write !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_issue got=%b want=1", mem_bus_write);
    end
    rst_n = 0;
    #1;
    checks++;
    if (mem_bus_write !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop got=%b want=0", mem_bus_write);
    end
    acked = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      acked |= m0_ack | m1_ack;
      step();
      rst_n = 1;
    end
    checks++;
    if (acked !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_noack got=%b want=0", acked);
    end
    m0_req = 1; m1_req = 1;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_tie got=%b want=10", {m0_gnt, m1_gnt});
    end
    step();
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_drop_req();
    bit busy;
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h1001_0008;
    @(negedge clk);
    step();
    idle_inputs();
    m1_req = 1; m1_we = 1; m1_addr = 32'h1001_0080; m1_wdata = 32'h77;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL drop_issue_gnt got=%b want=0", m1_gnt);
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({m1_gnt, m1_ack, m0_ack, m0_rdata} !==
        {3'b001, memf(32'h1001_0008)}) begin
      errors++;
      $display("FAIL drop_resp got=%b%b%b %h want=001 %h",
               m1_gnt, m1_ack, m0_ack, m0_rdata, memf(32'h1001_0008));
    end
    busy = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clk);
      busy |= m0_gnt | m1_gnt | mem_bus_read | mem_bus_write |
              m0_ack | m1_ack;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_quiet got=%b want=0", busy);
    end
  endtask

  task automatic test_random();
    bit          p_v[2];
    bit          p_we[2];
    logic [31:0] p_a[2];
    logic [31:0] p_d[2];
    bit          last;
    int          free_at;
    bit          t_v, t_port, t_we, t_err;
    logic [31:0] t_a, t_d;
    int          t_iss;
    int          w;
    logic        e_g[2], e_rd, e_wr, e_ack[2], e_err[2];
    logic [31:0] e_ra, e_wa, e_wd, e_rdat[2];
    logic [167:0] exp_v;
    do_reset();
    p_v = '{0, 0};
    last = 1; free_at = 0; t_v = 0; t_iss = -10;
    t_port = 0; t_we = 0; t_err = 0; t_a = 0; t_d = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (p_v[i]) begin
          if ($urandom_range(0, 7) == 0) p_v[i] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          p_v[i]  = 1;
          p_we[i] = 1'($urandom_range(0, 1));
          p_a[i]  = 32'h1001_0000 + ($urandom_range(0, 255) << 2);
          if ($urandom_range(0, 3) == 0)
            p_a[i][1:0] = 2'($urandom_range(1, 3));
          p_d[i]  = $urandom;
        end
      end
      m0_req = p_v[0]; m0_we = p_we[0];
      m0_addr = p_v[0] ? p_a[0] : $urandom;
      m0_wdata = p_d[0];
      m1_req = p_v[1]; m1_we = p_we[1];
      m1_addr = p_v[1] ? p_a[1] : $urandom;
      m1_wdata = p_d[1];
      @(negedge clk);
      e_g = '{0, 0}; e_ack = '{0, 0}; e_err = '{0, 0};
      e_rdat = '{0, 0};
      e_rd = 0; e_wr = 0; e_ra = 0; e_wa = 0; e_wd = 0;
      if (c >= free_at && (p_v[0] || p_v[1])) begin
        w = (p_v[0] && p_v[1]) ? int'(!last) : int'(p_v[1]);
        e_g[w] = 1;
        t_v = 1; t_port = w[0]; t_we = p_we[w];
        t_a = p_a[w]; t_d = p_d[w]; t_err = (p_a[w][1:0] != 0);
        t_iss = c + 1; free_at = c + 3; last = w[0];
        p_v[w] = 0;
      end
      if (t_v && c == t_iss && !t_err) begin
        if (t_we) begin
          e_wr = 1; e_wa = t_a; e_wd = t_d;
        end else begin
          e_rd = 1; e_ra = t_a;
        end
      end
      if (t_v && c == t_iss + 1) begin
        e_ack[t_port]  = 1;
        e_err[t_port]  = t_err;
        e_rdat[t_port] = (!t_we && !t_err) ? memf(t_a) : 32'h0;
      end
      exp_v = {e_g[0], e_g[1], e_rd, e_wr, e_ra, e_wa, e_wd,
               e_ack[0], e_err[0], e_rdat[0],
               e_ack[1], e_err[1], e_rdat[1]};
      checks++;
      if (outs() !== exp_v) begin
        errors++;
        $display("FAIL rand_c%0d got=%h want=%h", c, outs(), exp_v);
      end
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_misalign();
    test_reset_mid();
    test_drop_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
